// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Multicycle unsigned multiply/divide engine with architectural HI/LO
//   registers. It runs beside the single-cycle ALU so that MULTU and DIVU do
//   not need a combinational array. It also handles MTHI/MTLO writes, and it
//   drives the busy stall that freezes MFHI/MFLO.
//
//   Handshake: a request is taken on a rising edge where req_valid and
//   req_ready are both high. req_ready is high only in IDLE, so req_valid
//   outside IDLE is ignored. The requester may change or drop req_valid at
//   any time. There is no hold requirement.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   req_valid      op request present
//   req_ready      engine can accept (IDLE)
//   req_op         00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
//   op_a, op_b     operands (op_b ignored for MTHI/MTLO)
//   flush          cancels an in-flight MUL/DIV on the next edge
//   busy           MUL/DIV in progress
//   done           one-cycle pulse, op committed to HI/LO
//   div_by_zero    one-cycle pulse with done for DIVU by zero
//   hi, lo         architectural HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_opnd;   // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] r_acc;    // product high half (MUL) or remainder (DIV)
    logic [WIDTH-1:0] r_shf;    // multiplier/product low half (MUL) or quotient (DIV)
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dbz;

    // Multiply step: add the multiplicand when the multiplier LSB is set.
    // Then shift {carry, acc, multiplier} right by one.
    logic [WIDTH:0]   w_mul_add;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_mul_shf;

    assign w_mul_add = r_shf[0] ? {1'b0, r_opnd} : '0;
    assign w_mul_sum = {1'b0, r_acc} + w_mul_add;
    assign w_mul_acc = w_mul_sum[WIDTH:1];
    assign w_mul_shf = {w_mul_sum[0], r_shf[WIDTH-1:1]};

    // Restoring divide step: shift {rem, quo} left one and trial-subtract.
    // Before the shift the remainder is below the divisor. After a successful
    // subtract it fits in WIDTH bits again, so the subtraction can drop the
    // top bit.
    logic [WIDTH:0]   w_div_trial;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_sub;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    assign w_div_trial = {r_acc, r_shf[WIDTH-1]};
    assign w_div_ge    = (w_div_trial >= {1'b0, r_opnd});
    assign w_div_sub   = w_div_trial[WIDTH-1:0] - r_opnd;
    assign w_div_rem   = w_div_ge ? w_div_sub : w_div_trial[WIDTH-1:0];
    assign w_div_quo   = {r_shf[WIDTH-2:0], w_div_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_shf   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // flush has no effect here; a request is still taken.
                    if (req_valid) begin
                        case (req_op)
                            2'b00: begin
                                r_opnd  <= op_a;
                                r_shf   <= op_b;
                                r_acc   <= '0;
                                r_cnt   <= CW'(WIDTH - 1);
                                r_state <= ST_MUL;
                            end
                            2'b01: begin
                                if (op_b == '0) begin
                                    r_hi   <= op_a;
                                    r_lo   <= '1;
                                    r_done <= 1'b1;
                                    r_dbz  <= 1'b1;
                                end else begin
                                    r_opnd  <= op_b;
                                    r_shf   <= op_a;
                                    r_acc   <= '0;
                                    r_cnt   <= CW'(WIDTH - 1);
                                    r_state <= ST_DIV;
                                end
                            end
                            2'b10: begin
                                r_hi   <= op_a;
                                r_done <= 1'b1;
                            end
                            default: begin
                                r_lo   <= op_a;
                                r_done <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= w_mul_acc;
                        r_shf <= w_mul_shf;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == '0) begin
                            r_hi    <= w_mul_acc;
                            r_lo    <= w_mul_shf;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= w_div_rem;
                        r_shf <= w_div_quo;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == '0) begin
                            r_hi    <= w_div_rem;
                            r_lo    <= w_div_quo;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Table-driven bench for muldiv_sequencer, with hand-written sequences for
//   flush, flush-in-IDLE and reset during an op. Each committed result goes
//   into exp_q when its request is accepted. The monitor pops the entry when
//   done pulses and compares it with {div_by_zero, hi, lo}.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [2*W:0] exp_q[$];   // {div_by_zero, hi, lo}

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        logic         edbz;
        int           ebusy;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic chk(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Vector with explicit expected values; the model follows it.
    task automatic add(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic edbz, input int ebusy);
        vecs.push_back('{name, op, a, b, ehi, elo, edbz, ebusy});
        m_hi = ehi;
        m_lo = elo;
    endtask

    // Vector whose expectation comes from the arithmetic reference model.
    task automatic add_m(input string name, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W-1:0]   nhi;
        logic [W-1:0]   nlo;
        logic           dbz;
        int             bz;
        nhi = m_hi;
        nlo = m_lo;
        dbz = 1'b0;
        bz  = 0;
        case (op)
            2'b00: begin
                p   = (2*W)'(a) * (2*W)'(b);
                nhi = p[2*W-1:W];
                nlo = p[W-1:0];
                bz  = W;
            end
            2'b01: begin
                if (b == '0) begin
                    nhi = a;
                    nlo = '1;
                    dbz = 1'b1;
                end else begin
                    nhi = a % b;
                    nlo = a / b;
                    bz  = W;
                end
            end
            2'b10:   nhi = a;
            default: nlo = a;
        endcase
        add(name, op, a, b, nhi, nlo, dbz, bz);
    endtask

    // Driver: issues one op at a negedge and then follows it to its done
    // cycle. It returns at the negedge of the done cycle, so the next call
    // exercises back-to-back acceptance.
    task automatic do_op(input vec_t v);
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;
        int           busy_cnt;
        logic         got;
        logic         held;
        prev_hi  = hi;
        prev_lo  = lo;
        busy_cnt = 0;
        got      = 1'b0;
        held     = 1'b1;
        chk({v.name, "_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = v.op;
        op_a      = v.a;
        op_b      = v.b;
        @(posedge clk);
        exp_q.push_back({v.edbz, v.ehi, v.elo});
        @(negedge clk);
        req_valid = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        for (int i = 0; i < W + 8; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (hi !== prev_hi || lo !== prev_lo) held = 1'b0;
            @(negedge clk);
        end
        chk({v.name, "_done_seen"}, got, 1'b1);
        chk({v.name, "_busy_cycles"}, busy_cnt, v.ebusy);
        chk({v.name, "_hilo_held"}, held, 1'b1);
        chk({v.name, "_ready_in_done"}, req_ready, 1'b1);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", done, 1'b0);
                end else begin
                    chk("result", {div_by_zero, hi, lo}, exp_q.pop_front());
                end
            end else if (div_by_zero) begin
                chk("dbz_without_done", div_by_zero, 1'b0);
            end
        end
    end

    initial begin
        int n_done;

        // reset state
        @(negedge clk);
        chk("reset_hi", hi, '0);
        chk("reset_lo", lo, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_dbz", div_by_zero, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", req_ready, 1'b1);
        @(negedge clk);

        // vector table
        add("mul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, W);
        add("div_100_7", 2'b01, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, W);
        add("div_5_0", 2'b01, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 1'b1, 0);
        add("mthi", 2'b10, 32'h1234, 32'hFFFF0000, 32'h00001234, 32'hFFFFFFFF, 1'b0, 0);
        add("mtlo", 2'b11, 32'hABCD, 32'h0, 32'h00001234, 32'h0000ABCD, 1'b0, 0);
        add_m("mul_mixed", 2'b00, 32'h12345678, 32'h9ABCDEF0);
        add_m("mul_zero", 2'b00, 32'h0, 32'hFFFFFFFF);
        add_m("mul_one", 2'b00, 32'h1, 32'h80000001);
        add_m("div_by_one", 2'b01, 32'hDEADBEEF, 32'h1);
        add_m("div_small", 2'b01, 32'h3, 32'hFFFFFFF0);
        add_m("div_equal", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        add_m("div_msb", 2'b01, 32'h80000000, 32'h3);
        for (int i = 0; i < 6; i++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            add_m($sformatf("rand%0d", i), rop, ra, rb);
        end
        add_m("mthi_tail", 2'b10, 32'h600D, 32'h0);

        foreach (vecs[i]) do_op(vecs[i]);

        // flush during MULTU, with an ignored request held while busy
        req_valid = 1'b1;
        req_op    = 2'b00;
        op_a      = 32'd3;
        op_b      = 32'd4;
        @(posedge clk);
        @(negedge clk);
        req_op = 2'b10;
        op_a   = 32'hDEAD;
        for (int k = 1; k < 10; k++) begin
            if (k == 6) req_valid = 1'b0;
            @(negedge clk);
        end
        chk("flush_busy_before", busy, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_after", busy, 1'b0);
        chk("flush_ready_after", req_ready, 1'b1);
        chk("flush_hi", hi, m_hi);
        chk("flush_lo", lo, m_lo);
        n_done = 0;
        for (int k = 0; k < W + 8; k++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        chk("flush_no_done", n_done, 0);

        // flush in IDLE does not block a request
        flush = 1'b1;
        add_m("mtlo_flush_idle", 2'b11, 32'h5A5A, 32'h0);
        do_op(vecs[vecs.size()-1]);
        flush = 1'b0;

        // reset during DIVU 9/2 at busy cycle 5
        req_valid = 1'b1;
        req_op    = 2'b01;
        op_a      = 32'd9;
        op_b      = 32'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k < 5; k++) @(negedge clk);
        chk("rst_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_after", req_ready, 1'b1);
        @(negedge clk);
        m_hi = '0;
        m_lo = '0;
        add_m("div_9_2_after_rst", 2'b01, 32'd9, 32'd2);
        do_op(vecs[vecs.size()-1]);

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
